jtroadf_gfxarb: RTL and testbench

Arbiter that shares one SDRAM graphics read slot between the scroll tile fetcher and the object fetcher of the Road Fighter / Hyper Sports video path. Each requester gets a one-entry, 32-bit result register tagged with the last address it fetched. Repeated reads of the same word are served from that register without touching SDRAM. Misses are granted with fixed scroll priority plus an object anti-starvation counter, and are forwarded as a single `rom_cs`/`rom_addr` request that the SDRAM controller serves.

---
 rtl/jtroadf_gfxarb.sv | 110 +++++++++++
 tb/tb_jtroadf_gfxarb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtroadf_gfxarb.sv
// Shares one SDRAM graphics read slot between the scroll and object fetchers,
// with a one-word tagged result register per requester so that repeated reads hit locally.
module jtroadf_gfxarb #(
   parameter int          AW         = 14,
   parameter logic [AW:0] OBJ_OFFSET = 15'h4000,
   parameter int          STARVE     = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          scr_cs,
   input  logic [AW-1:0] scr_addr,
   output logic [31:0]   scr_data,
   output logic          scr_ok,
   input  logic          obj_cs,
   input  logic [AW-1:0] obj_addr,
   output logic [31:0]   obj_data,
   output logic          obj_ok,
   output logic          rom_cs,
   output logic [AW:0]   rom_addr,
   input  logic [31:0]   rom_data,
   input  logic          rom_ok
);

   typedef enum logic [1:0] {IDLE, WAIT0, WAIT} state_t;

   state_t        state;
   logic [AW-1:0] scr_tag;
   logic [AW-1:0] obj_tag;
   logic [AW-1:0] lat_addr;
   logic          scr_vld;
   logic          obj_vld;
   logic          owner;
   logic [2:0]    starve_cnt;

   logic          scr_miss;
   logic          obj_miss;
   logic          take_obj;
   logic          own_cs;
   logic [AW-1:0] own_addr;
   logic          abort;

   assign scr_ok   = scr_cs & scr_vld & (scr_tag == scr_addr);
   assign obj_ok   = obj_cs & obj_vld & (obj_tag == obj_addr);
   assign scr_miss = scr_cs & ~scr_ok;
   assign obj_miss = obj_cs & ~obj_ok;

   // Scroll wins unless the object side has been passed over STARVE times in a row.
   assign take_obj = obj_miss & ((starve_cnt == 3'(STARVE)) | ~scr_miss);

   // owner=1 means the object fetcher holds the slot
   assign own_cs   = owner ? obj_cs   : scr_cs;
   assign own_addr = owner ? obj_addr : scr_addr;
   assign abort    = ~own_cs | (own_addr != lat_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rom_cs     <= 1'b0;
         rom_addr   <= '0;
         lat_addr   <= '0;
         owner      <= 1'b0;
         starve_cnt <= 3'd0;
         scr_tag    <= '0;
         scr_vld    <= 1'b0;
         scr_data   <= 32'd0;
         obj_tag    <= '0;
         obj_vld    <= 1'b0;
         obj_data   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (scr_miss | obj_miss) begin
                  owner    <= take_obj;
                  lat_addr <= take_obj ? obj_addr : scr_addr;
                  rom_addr <= take_obj ? ({1'b0, obj_addr} + OBJ_OFFSET)
                                       : {1'b0, scr_addr};
                  rom_cs   <= 1'b1;
                  state    <= WAIT0;
               end
               if (take_obj | ~obj_miss)
                  starve_cnt <= 3'd0;
               else if (starve_cnt != 3'(STARVE))
                  starve_cnt <= starve_cnt + 3'd1;
            end
            // rom_ok may still be high from the previous access here
            WAIT0: state <= WAIT;
            WAIT: begin
               if (abort) begin
                  rom_cs <= 1'b0;
                  state  <= IDLE;
               end else if (rom_ok) begin
                  if (owner) begin
                     obj_data <= rom_data;
                     obj_tag  <= lat_addr;
                     obj_vld  <= 1'b1;
                  end else begin
                     scr_data <= rom_data;
                     scr_tag  <= lat_addr;
                     scr_vld  <= 1'b1;
                  end
                  rom_cs <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtroadf_gfxarb.sv
// Self-checking bench for jtroadf_gfxarb: the bench plays the SDRAM controller and
// keeps a queue of the SDRAM addresses it expects to be requested, in order.
module tb_jtroadf_gfxarb;

   logic        clk = 1'b0;
   logic        rst;
   logic        scr_cs;
   logic [13:0] scr_addr;
   logic [31:0] scr_data;
   logic        scr_ok;
   logic        obj_cs;
   logic [13:0] obj_addr;
   logic [31:0] obj_data;
   logic        obj_ok;
   logic        rom_cs;
   logic [14:0] rom_addr;
   logic [31:0] rom_data;
   logic        rom_ok;

   int total = 0;
   int bad   = 0;
   logic [14:0] exp_q[$];
   logic [14:0] exp_addr;
   bit          seen;

   jtroadf_gfxarb dut (
      .clk      (clk),
      .rst      (rst),
      .scr_cs   (scr_cs),
      .scr_addr (scr_addr),
      .scr_data (scr_data),
      .scr_ok   (scr_ok),
      .obj_cs   (obj_cs),
      .obj_addr (obj_addr),
      .obj_data (obj_data),
      .obj_ok   (obj_ok),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic wait_cs(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rom_cs) got = 1'b1;
      end
   endtask

   task automatic give_ok(input logic [31:0] d);
      rom_data = d;
      rom_ok   = 1'b1;
      @(negedge clk);
      rom_ok = 1'b0;
      #1;
   endtask

   task automatic pop_expect(output logic [14:0] e);
      if (exp_q.size() == 0) e = 15'h7fff;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset;
      rst = 1'b1; scr_cs = 1'b0; scr_addr = '0; obj_cs = 1'b0; obj_addr = '0;
      rom_data = '0; rom_ok = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL reset_rom_cs got=%b want=0", rom_cs); end
      total++; if (scr_data !== 32'd0 || obj_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h/%h want=0", scr_data, obj_data); end
      rst = 1'b0; scr_cs = 1'b1; scr_addr = 14'h0;
      exp_q.push_back(15'h0000);
      #1;
      total++; if (scr_ok !== 1'b0) begin bad++; $display("FAIL reset_no_false_hit got=%b want=0", scr_ok); end
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL reset_rom_cs_early got=%b want=0", rom_cs); end
      wait_cs(seen);
      total++; if (!seen) begin bad++; $display("FAIL reset_req_timeout got=0 want=1"); end
      pop_expect(exp_addr);
      total++; if (rom_addr !== exp_addr) begin bad++; $display("FAIL reset_rom_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      give_ok(32'h0000_1111);
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'h0000_1111) begin bad++; $display("FAIL reset_first_fill got=%b/%h want=1/00001111", scr_ok, scr_data); end
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL reset_fill_rom_cs got=%b want=0", rom_cs); end
      scr_cs = 1'b0;
   endtask

   task automatic test_miss_hit;
      @(negedge clk);
      scr_cs = 1'b1; scr_addr = 14'h123;
      exp_q.push_back(15'h0123);
      #1;
      total++; if (scr_ok !== 1'b0) begin bad++; $display("FAIL miss_ok got=%b want=0", scr_ok); end
      wait_cs(seen);
      total++; if (!seen) begin bad++; $display("FAIL miss_req_timeout got=0 want=1"); end
      pop_expect(exp_addr);
      total++; if (rom_addr !== exp_addr) begin bad++; $display("FAIL miss_rom_addr got=%h want=%h", rom_addr, exp_addr); end
      // stale rom_ok in the first request cycle must be ignored
      give_ok(32'hBAD0_BAD0);
      total++; if (scr_ok !== 1'b0 || rom_cs !== 1'b1) begin bad++; $display("FAIL miss_stale_ok got=%b/%b want=0/1", scr_ok, rom_cs); end
      @(negedge clk);
      @(negedge clk);
      give_ok(32'hDEAD_BEEF);
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL miss_fill got=%b/%h want=1/deadbeef", scr_ok, scr_data); end
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL miss_fill_rom_cs got=%b want=0", rom_cs); end
      scr_cs = 1'b0;
      repeat (3) @(negedge clk);
      scr_cs = 1'b1; scr_addr = 14'h123;
      #1;
      total++; if (scr_ok !== 1'b1 || obj_ok !== 1'b0) begin bad++; $display("FAIL hit_ok got=%b/%b want=1/0", scr_ok, obj_ok); end
      repeat (2) @(negedge clk);
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL hit_no_req got=%b want=0", rom_cs); end
      scr_cs = 1'b0;
   endtask

   task automatic test_offset_priority;
      @(negedge clk);
      scr_cs = 1'b1; scr_addr = 14'h5; obj_cs = 1'b1; obj_addr = 14'h5;
      exp_q.push_back(15'h0005);
      exp_q.push_back(15'h4005);
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL prio_scr_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      give_ok(32'h5555_0000);
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'h5555_0000 || obj_ok !== 1'b0) begin bad++; $display("FAIL prio_scr_fill got=%b/%h/%b want=1/55550000/0", scr_ok, scr_data, obj_ok); end
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL prio_obj_addr got=%h want=%h", rom_addr, exp_addr); end
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'h5555_0000) begin bad++; $display("FAIL prio_hit_during_miss got=%b/%h want=1/55550000", scr_ok, scr_data); end
      @(negedge clk);
      give_ok(32'h0B0B_0005);
      total++; if (obj_ok !== 1'b1 || obj_data !== 32'h0B0B_0005) begin bad++; $display("FAIL prio_obj_fill got=%b/%h want=1/0b0b0005", obj_ok, obj_data); end
      total++; if (scr_data !== 32'h5555_0000) begin bad++; $display("FAIL prio_scr_kept got=%h want=55550000", scr_data); end
      scr_cs = 1'b0; obj_cs = 1'b0;
   endtask

   task automatic test_starvation;
      @(negedge clk);
      obj_cs = 1'b1; obj_addr = 14'h777;
      scr_cs = 1'b1; scr_addr = 14'h100;
      exp_q.push_back(15'h0100);
      for (int i = 0; i < 4; i++) begin
         wait_cs(seen);
         pop_expect(exp_addr);
         total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL starve_grant%0d got=%h want=%h", i, rom_addr, exp_addr); end
         @(negedge clk);
         give_ok(32'h1000_0000 + 32'(i));
         total++; if (scr_ok !== 1'b1 || scr_data !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL starve_fill%0d got=%b/%h", i, scr_ok, scr_data); end
         scr_addr = 14'h101 + 14'(i);
         if (i < 3) exp_q.push_back(15'h101 + 15'(i));
         else begin
            exp_q.push_back(15'h4777);
            exp_q.push_back(15'h0104);
         end
      end
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL starve_obj_wins got=%h want=%h", rom_addr, exp_addr); end
      total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_cnt_clear got=%0d want=0", dut.starve_cnt); end
      @(negedge clk);
      give_ok(32'h0B1E_C777);
      total++; if (obj_ok !== 1'b1 || obj_data !== 32'h0B1E_C777) begin bad++; $display("FAIL starve_obj_fill got=%b/%h", obj_ok, obj_data); end
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL starve_scr_after got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      give_ok(32'h1000_0104);
      total++; if (scr_ok !== 1'b1 || obj_ok !== 1'b1) begin bad++; $display("FAIL starve_both_hit got=%b/%b want=1/1", scr_ok, obj_ok); end
      scr_cs = 1'b0; obj_cs = 1'b0;
   endtask

   task automatic test_abort;
      @(negedge clk);
      scr_cs = 1'b1; scr_addr = 14'h1;
      exp_q.push_back(15'h0001);
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL abort_first_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      scr_addr = 14'h2;
      exp_q.push_back(15'h0002);
      @(negedge clk);
      total++; if (rom_cs !== 1'b0 || scr_ok !== 1'b0) begin bad++; $display("FAIL abort_drop got=%b/%b want=0/0", rom_cs, scr_ok); end
      give_ok(32'hAAAA_0001);
      pop_expect(exp_addr);
      total++; if (rom_cs !== 1'b1 || rom_addr !== exp_addr || scr_ok !== 1'b0) begin bad++; $display("FAIL abort_retry got=%b/%h/%b want=1/%h/0", rom_cs, rom_addr, scr_ok, exp_addr); end
      @(negedge clk);
      give_ok(32'h2222_2222);
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'h2222_2222) begin bad++; $display("FAIL abort_retry_fill got=%b/%h want=1/22222222", scr_ok, scr_data); end
      @(negedge clk);
      scr_addr = 14'h3;
      exp_q.push_back(15'h0003);
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL abort2_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      scr_addr = 14'h4; rom_data = 32'h3333_3333; rom_ok = 1'b1;
      @(negedge clk);
      rom_ok = 1'b0;
      #1;
      total++; if (rom_cs !== 1'b0 || scr_ok !== 1'b0 || scr_data !== 32'h2222_2222) begin bad++; $display("FAIL abort_coincident got=%b/%b/%h want=0/0/22222222", rom_cs, scr_ok, scr_data); end
      scr_addr = 14'h3;
      exp_q.push_back(15'h0003);
      #1;
      total++; if (scr_ok !== 1'b0) begin bad++; $display("FAIL abort_not_stored got=%b want=0", scr_ok); end
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL abort2_retry_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      give_ok(32'h3333_0003);
      total++; if (scr_ok !== 1'b1 || scr_data !== 32'h3333_0003) begin bad++; $display("FAIL abort2_fill got=%b/%h want=1/33330003", scr_ok, scr_data); end
      scr_cs = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      scr_cs = 1'b1; scr_addr = 14'h200;
      exp_q.push_back(15'h0200);
      wait_cs(seen);
      pop_expect(exp_addr);
      total++; if (!seen || rom_addr !== exp_addr) begin bad++; $display("FAIL rstmid_addr got=%h want=%h", rom_addr, exp_addr); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rom_data = 32'hFEED_F00D; rom_ok = 1'b1;
      scr_addr = 14'h3; obj_cs = 1'b1; obj_addr = 14'h777;
      exp_q.push_back(15'h0003);
      #1;
      total++; if (rom_cs !== 1'b0 || rom_addr !== 15'h0) begin bad++; $display("FAIL rstmid_rom got=%b/%h want=0/0000", rom_cs, rom_addr); end
      total++; if (scr_ok !== 1'b0 || obj_ok !== 1'b0) begin bad++; $display("FAIL rstmid_ok got=%b/%b want=0/0", scr_ok, obj_ok); end
      total++; if (scr_data !== 32'd0 || obj_data !== 32'd0) begin bad++; $display("FAIL rstmid_data got=%h/%h want=0/0", scr_data, obj_data); end
      @(negedge clk);
      rom_ok = 1'b0;
      #1;
      pop_expect(exp_addr);
      total++; if (scr_ok !== 1'b0 || obj_ok !== 1'b0) begin bad++; $display("FAIL rstmid_late_ok got=%b/%b want=0/0", scr_ok, obj_ok); end
      total++; if (rom_cs !== 1'b1 || rom_addr !== exp_addr) begin bad++; $display("FAIL rstmid_new_req got=%b/%h want=1/%h", rom_cs, rom_addr, exp_addr); end
      scr_cs = 1'b0; obj_cs = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL rstmid_final got=%b want=0", rom_cs); end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_miss_hit();
      test_offset_priority();
      test_starvation();
      test_abort();
      test_reset_mid();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
